// File: rtl/snk_ctr_chk_if.sv
// AXI-stream beat channel carrying a counter ramp: tdata/tvalid from source, tready from sink.
interface snk_ctr_chk_if #(
  parameter int unsigned W = 5
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/snk_ctr_chk.sv
// AXIS sink that throttles tready periodically and checks accepted beats against a
// modulo counter ramp, reporting lock, match/error counts and the first mismatch.
module snk_ctr_chk #(
  parameter int unsigned MaxCnt  = 32,
  parameter int unsigned RdyCnt  = 24,
  parameter string       Order   = "processing",
  parameter int unsigned LockCnt = 2,
  parameter int unsigned CntW    = 16,
  localparam int unsigned W      = $clog2(MaxCnt)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  snk_ctr_chk_if.slave    s_axis,
  input  logic            en_i,
  input  logic            clr_i,
  output logic            locked_o,
  output logic            err_o,
  output logic [CntW-1:0] match_cnt_o,
  output logic [CntW-1:0] err_cnt_o,
  output logic [W-1:0]    first_err_exp_o,
  output logic [W-1:0]    first_err_got_o
);

  localparam bit          Natural = (Order == "natural");
  localparam int unsigned RunW    = (LockCnt < 2) ? 1 : $clog2(LockCnt + 1);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  // Ready generator: free-running and untouched by clr.
  logic [W-1:0] rctr_q, rctr_d;
  logic         tready_q;

  always_comb begin
    rctr_d = (32'(rctr_q) == MaxCnt - 1) ? '0 : rctr_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rctr_q   <= '0;
      tready_q <= 1'b0;
    end else begin
      rctr_q   <= rctr_d;
      tready_q <= en_i && (32'(rctr_d) < RdyCnt);
    end
  end

  assign s_axis.tready = tready_q;

  state_e            state_q;
  logic              locked_q, err_q;
  logic [CntW-1:0]   match_cnt_q, err_cnt_q;
  logic [W-1:0]      first_err_exp_q, first_err_got_q;
  logic [W-1:0]      exp_q;
  logic [RunW-1:0]   run_q;

  logic              beat;
  logic              in_seq;
  logic [W-1:0]      exp_nxt;
  logic [RunW-1:0]   run_nxt;

  always_comb begin
    beat    = s_axis.tvalid && tready_q;
    in_seq  = (s_axis.tdata == exp_q);
    exp_nxt = Natural ? s_axis.tdata + W'(1) : s_axis.tdata - W'(1);
    // run_q == 0 means no beat seen since reset/clr, so exp_q is meaningless.
    run_nxt = ((run_q == '0) || !in_seq) ? RunW'(1) : run_q + RunW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= StUnlocked;
      locked_q        <= 1'b0;
      err_q           <= 1'b0;
      match_cnt_q     <= '0;
      err_cnt_q       <= '0;
      first_err_exp_q <= '0;
      first_err_got_q <= '0;
      exp_q           <= '0;
      run_q           <= '0;
    end else if (clr_i) begin
      state_q         <= StUnlocked;
      locked_q        <= 1'b0;
      err_q           <= 1'b0;
      match_cnt_q     <= '0;
      err_cnt_q       <= '0;
      first_err_exp_q <= '0;
      first_err_got_q <= '0;
      run_q           <= '0;
    end else if (beat) begin
      exp_q <= exp_nxt;
      unique case (state_q)
        StUnlocked: begin
          run_q <= run_nxt;
          if (32'(run_nxt) >= LockCnt) begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
          end
        end
        StLocked: begin
          if (in_seq) begin
            if (match_cnt_q != '1) match_cnt_q <= match_cnt_q + CntW'(1);
          end else begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CntW'(1);
            err_q <= 1'b1;
            if (!err_q) begin
              first_err_exp_q <= exp_q;
              first_err_got_q <= s_axis.tdata;
            end
          end
        end
        default: state_q <= StUnlocked;
      endcase
    end
  end

  assign locked_o        = locked_q;
  assign err_o           = err_q;
  assign match_cnt_o     = match_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_exp_o = first_err_exp_q;
  assign first_err_got_o = first_err_got_q;

endmodule

// File: tb/tb_snk_ctr_chk.sv
// Randomized bench: two differently configured sinks checked every cycle against a
// behavioural model built from cycle counts, modulo arithmetic and plain counters.
module tb_snk_ctr_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_a, clr_a, en_b, clr_b;

  snk_ctr_chk_if #(.W(2)) a_if ();
  snk_ctr_chk_if #(.W(3)) b_if ();

  logic        locked_a, err_a;
  logic [15:0] mc_a, ec_a;
  logic [1:0]  fe_a, fg_a;
  logic        locked_b, err_b;
  logic [1:0]  mc_b, ec_b;
  logic [2:0]  fe_b, fg_b;

  // A: natural order with back pressure; B: processing order, full ready, tiny counters.
  snk_ctr_chk #(
    .MaxCnt (4),
    .RdyCnt (3),
    .Order  ("natural"),
    .LockCnt(2),
    .CntW   (16)
  ) u_dut_a (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .s_axis         (a_if),
    .en_i           (en_a),
    .clr_i          (clr_a),
    .locked_o       (locked_a),
    .err_o          (err_a),
    .match_cnt_o    (mc_a),
    .err_cnt_o      (ec_a),
    .first_err_exp_o(fe_a),
    .first_err_got_o(fg_a)
  );

  snk_ctr_chk #(
    .MaxCnt (8),
    .RdyCnt (8),
    .Order  ("processing"),
    .LockCnt(3),
    .CntW   (2)
  ) u_dut_b (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .s_axis         (b_if),
    .en_i           (en_b),
    .clr_i          (clr_b),
    .locked_o       (locked_b),
    .err_o          (err_b),
    .match_cnt_o    (mc_b),
    .err_cnt_o      (ec_b),
    .first_err_exp_o(fe_b),
    .first_err_got_o(fg_b)
  );

  function automatic int maxc(input int i);  return (i == 0) ? 4 : 8;  endfunction
  function automatic int rdyc(input int i);  return (i == 0) ? 3 : 8;  endfunction
  function automatic int lockc(input int i); return (i == 0) ? 2 : 3;  endfunction
  function automatic int satm(input int i);  return (i == 0) ? 65535 : 3; endfunction
  function automatic int stepc(input int i); return (i == 0) ? 1 : maxc(i) - 1; endfunction

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state per sink.
  int m_k[2], m_rdy[2], m_lock[2], m_err[2], m_mc[2], m_ec[2];
  int m_fexp[2], m_fgot[2], m_exp[2], m_run[2];

  task automatic model_step(input int i, input bit rst, input bit en, input bit clr,
                            input bit tv, input int td);
    if (!rst) begin
      m_k[i] = 0; m_rdy[i] = 0; m_lock[i] = 0; m_err[i] = 0; m_mc[i] = 0; m_ec[i] = 0;
      m_fexp[i] = 0; m_fgot[i] = 0; m_exp[i] = 0; m_run[i] = 0;
      return;
    end
    if (clr) begin
      m_lock[i] = 0; m_err[i] = 0; m_mc[i] = 0; m_ec[i] = 0;
      m_fexp[i] = 0; m_fgot[i] = 0; m_run[i] = 0;
    end else if (tv && m_rdy[i] != 0) begin
      if (m_lock[i] == 0) begin
        if (m_run[i] == 0 || td != m_exp[i]) m_run[i] = 1;
        else m_run[i]++;
        if (m_run[i] >= lockc(i)) m_lock[i] = 1;
      end else if (td == m_exp[i]) begin
        if (m_mc[i] < satm(i)) m_mc[i]++;
      end else begin
        if (m_ec[i] < satm(i)) m_ec[i]++;
        if (m_err[i] == 0) begin
          m_fexp[i] = m_exp[i];
          m_fgot[i] = td;
        end
        m_err[i] = 1;
      end
      m_exp[i] = (td + stepc(i)) % maxc(i);
    end
    // tready in the cycle after the k-th live edge follows the position k within the period.
    m_k[i]++;
    m_rdy[i] = (en && ((m_k[i] % maxc(i)) < rdyc(i))) ? 1 : 0;
  endtask

  task automatic check_dut(input int i);
    if (i == 0) begin
      check_eq("A.tready", int'(a_if.tready), m_rdy[0]);
      check_eq("A.locked", int'(locked_a), m_lock[0]);
      check_eq("A.err", int'(err_a), m_err[0]);
      check_eq("A.match_cnt", int'(mc_a), m_mc[0]);
      check_eq("A.err_cnt", int'(ec_a), m_ec[0]);
      check_eq("A.first_err_exp", int'(fe_a), m_fexp[0]);
      check_eq("A.first_err_got", int'(fg_a), m_fgot[0]);
    end else begin
      check_eq("B.tready", int'(b_if.tready), m_rdy[1]);
      check_eq("B.locked", int'(locked_b), m_lock[1]);
      check_eq("B.err", int'(err_b), m_err[1]);
      check_eq("B.match_cnt", int'(mc_b), m_mc[1]);
      check_eq("B.err_cnt", int'(ec_b), m_ec[1]);
      check_eq("B.first_err_exp", int'(fe_b), m_fexp[1]);
      check_eq("B.first_err_got", int'(fg_b), m_fgot[1]);
    end
  endtask

  // Mostly feed the expected next value so the sinks lock, with occasional jumps.
  function automatic int pick_data(input int i);
    if (m_run[i] > 0 && $urandom_range(0, 9) != 0) return m_exp[i];
    return int'($urandom_range(0, maxc(i) - 1));
  endfunction

  initial begin
    int  td_a, td_b;
    bit  tv_a, tv_b;
    rst_n = 1'b0;
    en_a = 1'b0; clr_a = 1'b0; en_b = 1'b0; clr_b = 1'b0;
    a_if.tdata = '0; a_if.tvalid = 1'b0;
    b_if.tdata = '0; b_if.tvalid = 1'b0;
    for (int i = 0; i < 2; i++) model_step(i, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 4000; n++) begin
      rst_n = (n < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
      en_a  = ($urandom_range(0, 19) != 0);
      en_b  = ($urandom_range(0, 19) != 0);
      clr_a = (n > 2) && ($urandom_range(0, 99) == 0);
      clr_b = (n > 2) && ($urandom_range(0, 99) == 0);
      tv_a  = ($urandom_range(0, 3) != 0);
      tv_b  = ($urandom_range(0, 3) != 0);
      td_a  = pick_data(0);
      td_b  = pick_data(1);
      a_if.tvalid = tv_a;
      a_if.tdata  = 2'(td_a);
      b_if.tvalid = tv_b;
      b_if.tdata  = 3'(td_b);

      model_step(0, rst_n, en_a, clr_a, tv_a, td_a);
      model_step(1, rst_n, en_b, clr_b, tv_b, td_b);

      @(posedge clk);
      #1;
      check_dut(0);
      check_dut(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
